// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the RV32I load/store unit.
// Holds the funct3 encodings, FSM states and the error-check functions.
package lsu_pkg;

    localparam int LSU_XLEN = 32;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_e;

    function automatic logic is_misaligned(
        input logic [2:0] f3,
        input logic [1:0] a
    );
        logic r;
        r = 1'b0;
        case (f3)
            LSU_H, LSU_HU: r = a[0];
            LSU_W:         r = |a;
            default:       r = 1'b0;
        endcase
        return r;
    endfunction

    // Stores only know B/H/W; loads add the unsigned variants.
    function automatic logic is_illegal(
        input logic       we,
        input logic [2:0] f3
    );
        logic r;
        r = 1'b1;
        case (f3)
            LSU_B, LSU_H, LSU_W: r = 1'b0;
            LSU_BU, LSU_HU:      r = we;
            default:             r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and RAM-side bundle of the load/store unit.
// master: core + RAM side; slave: the load/store unit itself.
interface lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_wr_en, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_wr_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit_align.sv
// Lane alignment for the load/store unit (purely combinational).
// In: funct3, addr[1:0], old_word, wdata. Out: load_ext, store_merged.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic [31:0] store_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = old_word[{addr, 3'b000} +: 8];
        w_half = addr[1] ? old_word[31:16] : old_word[15:0];

        load_ext = '0;
        case (funct3)
            LSU_B:   load_ext = {{24{w_byte[7]}}, w_byte};
            LSU_BU:  load_ext = {24'b0, w_byte};
            LSU_H:   load_ext = {{16{w_half[15]}}, w_half};
            LSU_HU:  load_ext = {16'b0, w_half};
            LSU_W:   load_ext = old_word;
            default: load_ext = '0;
        endcase

        store_merged = old_word;
        case (funct3)
            LSU_B: store_merged[{addr, 3'b000} +: 8] = wdata[7:0];
            LSU_H: begin
                if (addr[1]) store_merged[31:16] = wdata[15:0];
                else         store_merged[15:0]  = wdata[15:0];
            end
            LSU_W:   store_merged = wdata;
            default: store_merged = old_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns LB/LH/LW/LBU/LHU/SB/SH/SW into word RAM
// accesses. Ports: clk, reset (async, active-high), bus (lsu_if.slave).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic   clk,
    input  logic   reset,
    lsu_if.slave   bus
);

    state_e r_state;
    state_e w_next;

    logic              r_we;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_old;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic              w_accept;
    logic              w_bad;
    logic [DATA_W-1:0] w_align_word;
    logic [DATA_W-1:0] w_load_ext;
    logic [DATA_W-1:0] w_store_merged;

    assign w_accept = bus.req_valid && (r_state == IDLE);
    assign w_bad    = is_illegal(bus.req_we, bus.req_funct3) ||
                      is_misaligned(bus.req_funct3, bus.req_addr[1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_bad)
                        w_next = RESP;
                    else if (bus.req_we && bus.req_funct3 == LSU_W)
                        w_next = WRITE;
                    else
                        w_next = READ;
                end
            end
            READ:    w_next = r_we ? WRITE : RESP;
            WRITE:   w_next = RESP;
            RESP:    if (bus.rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_old    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we     <= bus.req_we;
                r_funct3 <= bus.req_funct3;
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
                r_err    <= w_bad;
                r_rdata  <= '0;
            end
            if (r_state == READ) begin
                r_old   <= bus.mem_rdata;
                r_rdata <= r_we ? '0 : w_load_ext;
            end
            if (r_state == WRITE) r_rdata <= '0;
        end
    end

    // READ extracts straight from the RAM; WRITE merges into the saved word.
    assign w_align_word = (r_state == READ) ? bus.mem_rdata : r_old;

    lsu_align u_align (
        .funct3       (r_funct3),
        .addr         (r_addr[1:0]),
        .old_word     (w_align_word),
        .wdata        (r_wdata),
        .load_ext     (w_load_ext),
        .store_merged (w_store_merged)
    );

    assign bus.req_ready = (r_state == IDLE);
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign bus.mem_wr_en = (r_state == WRITE);
    assign bus.mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign bus.mem_wdata = w_store_merged;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-word RAM model.
// Covers reset, loads, sub-word stores, errors, back-pressure, reset mid-write.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    logic [31:0] ram [0:63];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;

    lsu_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = ram[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (pl_en)              ram[pl_idx] <= pl_val;
        else if (bus.mem_wr_en) ram[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        pl_idx = idx;
        pl_val = val;
        pl_en  = 1'b1;
        @(posedge clk); #1;
        pl_en  = 1'b0;
    endtask

    task automatic run(
        input  logic        we,
        input  logic [2:0]  f3,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        input  int          hold,
        output logic [31:0] rd,
        output logic        er,
        output int          lat,
        output int          nwr,
        output logic [31:0] wa,
        output logic [31:0] ww
    );
        int g;
        g = 0;
        while (!bus.req_ready && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        nwr = 0;
        wa  = '0;
        ww  = '0;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.rsp_ready  = (hold == 0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            if (bus.mem_wr_en) begin
                nwr++;
                wa = bus.mem_addr;
                ww = bus.mem_wdata;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (bus.mem_wr_en) nwr++;
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_rdata", bus.rsp_rdata, rd);
            chk("hold_err", 32'(bus.rsp_err), 32'(er));
            chk("hold_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          nwr;
        logic [31:0] wa;
        logic [31:0] ww;

        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        pl_en  = 1'b0;
        pl_idx = '0;
        pl_val = '0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b1;

        @(posedge clk); #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);

        preload(6'd63, 32'hF0F0F0F0);
        preload(6'd62, 32'h87654321);
        reset = 1'b0;
        @(posedge clk); #1;

        run(1'b0, LSU_B, 32'hFC, 32'h0, 0, rd, er, lat, nwr, wa, ww);
        chk("lb_data", rd, 32'hFFFFFFF0);
        chk("lb_err", 32'(er), 32'd0);
        chk("lb_lat", 32'(lat), 32'd2);
        chk("lb_nwr", 32'(nwr), 32'd0);

        run(1'b0, LSU_BU, 32'hFC, 32'h0, 0, rd, er, lat, nwr, wa, ww);
        chk("lbu_data", rd, 32'h000000F0);
        chk("lbu_err", 32'(er), 32'd0);

        run(1'b0, LSU_H, 32'hFA, 32'h0, 0, rd, er, lat, nwr, wa, ww);
        chk("lh_data", rd, 32'hFFFF8765);
        chk("lh_lat", 32'(lat), 32'd2);

        run(1'b0, LSU_HU, 32'hFA, 32'h0, 0, rd, er, lat, nwr, wa, ww);
        chk("lhu_data", rd, 32'h00008765);

        run(1'b0, LSU_W, 32'hF8, 32'h0, 0, rd, er, lat, nwr, wa, ww);
        chk("lw_data", rd, 32'h87654321);

        run(1'b1, LSU_B, 32'hF9, 32'h000000AB, 0, rd, er, lat, nwr, wa, ww);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_nwr", 32'(nwr), 32'd1);
        chk("sb_waddr", wa, 32'hF8);
        chk("sb_wdata", ww, 32'h8765AB21);
        chk("sb_rdata", rd, 32'd0);
        chk("sb_err", 32'(er), 32'd0);

        run(1'b0, LSU_W, 32'hF8, 32'h0, 0, rd, er, lat, nwr, wa, ww);
        chk("lw_after_sb", rd, 32'h8765AB21);

        run(1'b0, LSU_B, 32'hFB, 32'h0, 0, rd, er, lat, nwr, wa, ww);
        chk("lb_lane3", rd, 32'hFFFFFF87);

        run(1'b0, LSU_W, 32'hF9, 32'h0, 0, rd, er, lat, nwr, wa, ww);
        chk("lw_mis_err", 32'(er), 32'd1);
        chk("lw_mis_rdata", rd, 32'd0);
        chk("lw_mis_lat", 32'(lat), 32'd1);
        chk("lw_mis_nwr", 32'(nwr), 32'd0);

        run(1'b1, LSU_H, 32'h03, 32'hFFFF, 0, rd, er, lat, nwr, wa, ww);
        chk("sh_mis_err", 32'(er), 32'd1);
        chk("sh_mis_rdata", rd, 32'd0);
        chk("sh_mis_lat", 32'(lat), 32'd1);
        chk("sh_mis_nwr", 32'(nwr), 32'd0);

        run(1'b0, 3'b011, 32'h00, 32'h0, 0, rd, er, lat, nwr, wa, ww);
        chk("f3_011_err", 32'(er), 32'd1);
        chk("f3_011_rdata", rd, 32'd0);
        chk("f3_011_nwr", 32'(nwr), 32'd0);

        run(1'b1, LSU_BU, 32'h04, 32'h55, 0, rd, er, lat, nwr, wa, ww);
        chk("sbu_err", 32'(er), 32'd1);
        chk("sbu_nwr", 32'(nwr), 32'd0);

        run(1'b1, LSU_W, 32'h00, 32'h12345678, 3, rd, er, lat, nwr, wa, ww);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_nwr", 32'(nwr), 32'd1);
        chk("sw_wdata", ww, 32'h12345678);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_err", 32'(er), 32'd0);

        run(1'b0, LSU_W, 32'h00, 32'h0, 0, rd, er, lat, nwr, wa, ww);
        chk("lw_after_sw", rd, 32'h12345678);

        run(1'b1, LSU_H, 32'h02, 32'h0000BEEF, 0, rd, er, lat, nwr, wa, ww);
        chk("sh_lat", 32'(lat), 32'd3);
        chk("sh_wdata", ww, 32'hBEEF5678);
        chk("sh_waddr", wa, 32'h0);

        run(1'b0, LSU_H, 32'h02, 32'h0, 0, rd, er, lat, nwr, wa, ww);
        chk("lh_upper", rd, 32'hFFFFBEEF);

        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = LSU_B;
        bus.req_addr   = 32'hF9;
        bus.req_wdata  = 32'h000000CD;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_write", 32'(bus.mem_wr_en), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_wren_drop", 32'(bus.mem_wr_en), 32'd0);
        @(posedge clk); #1;
        chk("rst_no_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_ram_kept", ram[62], 32'h8765AB21);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready_after", 32'(bus.req_ready), 32'd1);
        chk("rst_no_valid2", 32'(bus.rsp_valid), 32'd0);

        run(1'b0, LSU_W, 32'hF8, 32'h0, 0, rd, er, lat, nwr, wa, ww);
        chk("lw_after_rst", rd, 32'h8765AB21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's memory stage and the word-wide data RAM (32-bit words, word index = addr[31:2], combinational read, write on clock edge).
- Turns RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into RAM word accesses.
- Sub-word stores use read-modify-write. Load data is extracted and sign/zero-extended.
- Misaligned addresses and illegal funct3 values return an error response.

Parameters:
- ADDR_W, 32, byte-address width of req_addr and mem_addr.
- DATA_W, 32, data width. Fixed at 32; any other value is unsupported.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data, right-aligned
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts the response
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  misaligned access or illegal funct3
- mem_wr_en  output  1  RAM write enable
- mem_addr  output  ADDR_W  RAM address, always {addr[31:2],2'b00}
- mem_wdata  output  32  merged RAM write word
- mem_rdata  input  32  RAM combinational read word

Behaviour:
- Clock/reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_wr_en=0, mem_addr=0, mem_wdata=0. All request latches cleared.
- States: IDLE, READ, WRITE, RESP.
- Accept: request is accepted on a clk edge when req_valid && req_ready. At that edge the unit latches we, funct3, addr and wdata.
- req_ready = (state==IDLE). No request is accepted in any other state.
- Error check at accept:
  - Illegal funct3: 011, 110, 111; any funct3 other than 000/001/010 when we=1.
  - Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0.
  - On error: go to RESP with rsp_err=1, rsp_rdata=0. Never assert mem_wr_en.
- Transitions from IDLE on accept:
  - Load → READ.
  - SB/SH → READ.
  - SW → WRITE (no read needed).
- READ (1 cycle):
  - Drive mem_addr from the latched address and capture mem_rdata into the old-word register.
  - Load → RESP, with the extended data registered into rsp_rdata.
  - SB/SH → WRITE.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - B/H sign-extend from bit 7/15. BU/HU zero-extend. W passes the word unchanged.
- WRITE (1 cycle):
  - mem_wr_en=1 for exactly this one cycle.
  - mem_wdata = old word with the selected lane replaced by wdata[7:0] / wdata[15:0]; SW uses wdata as-is.
  - Next state RESP with rsp_rdata=0.
- RESP:
  - rsp_valid=1, with rsp_rdata and rsp_err held stable until rsp_ready.
  - On the rsp_valid && rsp_ready edge → IDLE. A new request may be accepted in the following cycle.
- mem_wr_en is 0 in every state except WRITE.
- mem_addr holds its last value in IDLE and RESP.
- Latency, accept edge to rsp_valid high, with rsp_ready tied 1:
  - Load: 2 cycles.
  - SB/SH: 3 cycles.
  - SW: 2 cycles.
  - Error: 1 cycle.
- Throughput: one transaction in flight; no pipelining.
- Reset mid-operation (any state): mem_wr_en drops immediately, the FSM returns to IDLE, and the in-flight transaction is lost with no response. A write is never partially committed after reset deasserts.

Decomposition:
- lsu_pkg:
  - typedef enum for funct3 (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU).
  - typedef enum state_e (IDLE, READ, WRITE, RESP).
  - Function is_misaligned(funct3, addr[1:0]).
- Sub-module lsu_align (purely combinational):
  - Inputs: funct3, addr[1:0], old_word, wdata.
  - Outputs: load_ext[31:0] and store_merged[31:0].
  - Shared by both paths and unit-testable alone.

Test Plan:
- RAM word at 0xFC = 0xF0F0F0F0:
  - LB addr 0xFC → rsp_rdata=0xFFFFFFF0, rsp_err=0.
  - LBU addr 0xFC → 0x000000F0.
  - rsp_valid rises 2 cycles after accept.
- RAM word at 0xF8 = 0x87654321:
  - LH addr 0xFA → 0xFFFF8765.
  - LHU addr 0xFA → 0x00008765.
  - LW addr 0xF8 → 0x87654321.
- SB wdata=0x000000AB addr 0xF9 → mem_wr_en high for exactly 1 cycle with mem_addr=0xF8 and mem_wdata=0x8765AB21, rsp_valid 3 cycles after accept; a following LW 0xF8 returns 0x8765AB21.
- LW addr 0xF9, then SH addr 0x03, then funct3=011 → each gives rsp_err=1, rsp_rdata=0, mem_wr_en never asserted.
- SW 0x12345678 addr 0x00 with rsp_ready=0 for 3 cycles → rsp_valid, rsp_rdata and rsp_err stable, req_ready=0; after the handshake a LW 0x00 returns 0x12345678.
- SB in progress, reset asserted in the WRITE cycle → mem_wr_en=0 immediately, RAM word unchanged, no rsp_valid, req_ready=1 after reset deasserts.
